// File: rtl/div_pkg.sv
// div_pkg: shared types and constants for the sequential divider.
//   div_state_e        - divider FSM states
//   DIV_DIVIDEND_W     - default dividend / quotient width
//   DIV_DIVISOR_W      - default divisor / remainder width
//   DIV_CNT_W          - step counter width for the default dividend width
//   DIV_ZERO_QUOTIENT  - quotient reported on divide-by-zero
package div_pkg;

  localparam int unsigned DIV_DIVIDEND_W = 24;
  localparam int unsigned DIV_DIVISOR_W  = 12;
  localparam int unsigned DIV_CNT_W      = $clog2(DIV_DIVIDEND_W + 1);

  localparam logic [DIV_DIVIDEND_W-1:0] DIV_ZERO_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step.
//   rem_i [W:0]   - current partial remainder (always < dvs_i)
//   bit_i         - next dividend bit, shifted in at the LSB
//   dvs_i [W-1:0] - divisor magnitude
//   rem_o [W:0]   - next partial remainder
//   q_o           - quotient bit produced by this step
module div_step #(
  parameter int unsigned W = 12
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] shifted;

  // rem_i stays below the divisor, so its top bit is never set in practice;
  // folding it into the compare keeps the step correct for any input anyway.
  always_comb begin
    shifted = {rem_i[W-1:0], bit_i};
    q_o     = rem_i[W] | (shifted >= {1'b0, dvs_i});
    rem_o   = q_o ? (shifted - {1'b0, dvs_i}) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
//   clock, reset_n      - rising-edge clock, asynchronous active-low reset
//   start               - request, sampled only in IDLE
//   signed_mode         - 1 = two's-complement operands, captured with start
//   dividend, divisor   - operands, captured on the start edge
//   busy                - high from the start edge until done
//   done                - one-cycle pulse, results valid from this cycle on
//   quotient, remainder - registered results, held until the next load
//   div_by_zero         - registered flag, valid with done
//   overflow            - registered flag (signed most-negative / -1 only)
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int unsigned DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  // Holds the dividend magnitude on entry; quotient bits shift in at the LSB
  // as dividend bits leave at the MSB, so it ends up holding the quotient.
  logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic                  q_neg_q, q_neg_d;
  logic                  r_neg_q, r_neg_d;
  logic                  zero_q, zero_d;
  logic                  ovf_q, ovf_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;
  logic                  overflow_q, overflow_d;

  logic [DIVIDEND_W-1:0] dvd_mag;
  logic [DIVISOR_W-1:0]  dvs_mag;
  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(
    .W(DIVISOR_W)
  ) u_step (
    .rem_i(rem_q),
    .bit_i(dvd_q[DIVIDEND_W-1]),
    .dvs_i(dvs_q),
    .rem_o(step_rem),
    .q_o  (step_q)
  );

  always_comb begin
    dvd_mag = (signed_mode && dividend[DIVIDEND_W-1]) ? -dividend : dividend;
    dvs_mag = (signed_mode && divisor[DIVISOR_W-1])   ? -divisor  : divisor;

    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    overflow_d  = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          q_neg_d = signed_mode & (dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1]);
          r_neg_d = signed_mode & dividend[DIVIDEND_W-1];
          ovf_d   = signed_mode
                    && (dividend == {1'b1, {(DIVIDEND_W-1){1'b0}}})
                    && (divisor == '1);
          dvs_d   = dvs_mag;
          if (divisor == '0) begin
            // Routed through FIX so the zero-divisor load shares the normal
            // result path and done lands one edge after the start edge.
            zero_d  = 1'b1;
            dvd_d   = dividend;
            state_d = FIX;
          end else begin
            zero_d  = 1'b0;
            dvd_d   = dvd_mag;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        rem_d = step_rem;
        dvd_d = {dvd_q[DIVIDEND_W-2:0], step_q};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        dbz_d      = zero_q;
        overflow_d = ovf_q & ~zero_q;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = dvd_q[DIVISOR_W-1:0];
        end else if (ovf_q) begin
          quotient_d  = {1'b1, {(DIVIDEND_W-1){1'b0}}};
          remainder_d = '0;
        end else begin
          quotient_d  = q_neg_q ? -dvd_q : dvd_q;
          remainder_d = r_neg_q ? -rem_q[DIVISOR_W-1:0] : rem_q[DIVISOR_W-1:0];
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      overflow_q  <= overflow_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed-vector bench for seq_divider.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        signed_mode;
  logic [23:0] dividend;
  logic [11:0] divisor;
  logic        busy;
  logic        done;
  logic [23:0] quotient;
  logic [11:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  seq_divider #(
    .DIVIDEND_W(24),
    .DIVISOR_W (12)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .signed_mode(signed_mode),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands with start high across one rising edge (E0); returns
  // #1 after E0, i.e. in cycle 1 of the division.
  task automatic launch(input logic sm, input logic [23:0] dvd, input logic [11:0] dvs);
    signed_mode = sm;
    dividend    = dvd;
    divisor     = dvs;
    start       = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Counts cycles until done; lat = cycle index of done (0 on timeout).
  // poke > 0 raises a stray start with different operands in that cycle.
  task automatic wait_done(input int poke, output int lat, output logic busy_ok);
    busy_ok = 1'b1;
    lat     = 0;
    for (int n = 1; n <= 60; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (n == poke) begin
        start       = 1'b1;
        signed_mode = 1'b0;
        dividend    = 24'd50;
        divisor     = 12'd5;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
    end
    start = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic sm, input logic [23:0] dvd,
                         input logic [11:0] dvs, input logic [23:0] eq, input logic [11:0] er,
                         input logic edbz, input logic eovf, input int elat, input int poke);
    int   lat;
    logic bok;
    launch(sm, dvd, dvs);
    wait_done(poke, lat, bok);
    expect_eq({tag, "_lat"}, lat, elat);
    expect_eq({tag, "_busy_held"}, {31'd0, bok}, 32'd1);
    expect_eq({tag, "_busy_drop"}, {31'd0, busy}, 32'd0);
    expect_eq({tag, "_q"}, {8'd0, quotient}, {8'd0, eq});
    expect_eq({tag, "_r"}, {20'd0, remainder}, {20'd0, er});
    expect_eq({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    expect_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
    @(posedge clock); #1;
    expect_eq({tag, "_pulse"}, {31'd0, done}, 32'd0);
    expect_eq({tag, "_hold"}, {8'd0, quotient}, {8'd0, eq});
  endtask

  initial begin
    int   lat;
    logic bok;
    logic seen;

    reset_n     = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    dividend    = '0;
    divisor     = '0;
    #2 reset_n  = 1'b0;
    #2;
    expect_eq("rst_busy", {31'd0, busy}, 32'd0);
    expect_eq("rst_done", {31'd0, done}, 32'd0);
    expect_eq("rst_q", {8'd0, quotient}, 32'd0);
    expect_eq("rst_r", {20'd0, remainder}, 32'd0);
    expect_eq("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    expect_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    //       tag        sm    dividend      divisor   quotient      rem      dbz   ovf  lat poke
    run_vec("u1000_7",  1'b0, 24'd1000,     12'd7,    24'd142,      12'd6,   1'b0, 1'b0, 26, 0);
    run_vec("s_m100_7", 1'b1, 24'hFFFF9C,   12'd7,    24'hFFFFF2,   12'hFFE, 1'b0, 1'b0, 26, 0);
    run_vec("s_100_m7", 1'b1, 24'd100,      12'hFF9,  24'hFFFFF2,   12'h002, 1'b0, 1'b0, 26, 0);
    run_vec("s_m100_m7",1'b1, 24'hFFFF9C,   12'hFF9,  24'h00000E,   12'hFFE, 1'b0, 1'b0, 26, 0);
    run_vec("s_m1_2",   1'b1, 24'hFFFFFF,   12'd2,    24'h000000,   12'hFFF, 1'b0, 1'b0, 26, 0);
    run_vec("dbz",      1'b0, 24'h123456,   12'h000,  24'hFFFFFF,   12'h456, 1'b1, 1'b0, 2,  0);
    run_vec("s_ovf",    1'b1, 24'h800000,   12'hFFF,  24'h800000,   12'h000, 1'b0, 1'b1, 26, 0);
    run_vec("u_minmax", 1'b0, 24'h800000,   12'hFFF,  24'h000800,   12'h800, 1'b0, 1'b0, 26, 0);
    run_vec("s_min_800",1'b1, 24'h800000,   12'h800,  24'h001000,   12'h000, 1'b0, 1'b0, 26, 0);
    run_vec("u_round",  1'b0, 24'hFFE001,   12'hFFF,  24'd4095,     12'd0,   1'b0, 1'b0, 26, 0);
    run_vec("u_small",  1'b0, 24'd5,        12'd9,    24'd0,        12'd5,   1'b0, 1'b0, 26, 0);
    run_vec("poke",     1'b0, 24'd1000,     12'd7,    24'd142,      12'd6,   1'b0, 1'b0, 26, 5);

    // Start held through the done cycle: ignored there, accepted in IDLE.
    launch(1'b0, 24'd300, 12'd9);
    wait_done(0, lat, bok);
    expect_eq("b2b_first_lat", lat, 32'd26);
    expect_eq("b2b_first_q", {8'd0, quotient}, 32'd33);
    signed_mode = 1'b0;
    dividend    = 24'd77;
    divisor     = 12'd0;
    start       = 1'b1;
    @(posedge clock); #1;
    expect_eq("b2b_ignored", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    expect_eq("b2b_accept", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done(0, lat, bok);
    expect_eq("b2b_lat", lat, 32'd2);
    expect_eq("b2b_q", {8'd0, quotient}, 32'h00FFFFFF);
    expect_eq("b2b_r", {20'd0, remainder}, 32'h04D);
    expect_eq("b2b_dbz", {31'd0, div_by_zero}, 32'd1);
    @(posedge clock); #1;

    // Reset in cycle 10 of a division clears everything and suppresses done.
    launch(1'b1, 24'hFFFF9C, 12'd7);
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    #1;
    expect_eq("abort_busy", {31'd0, busy}, 32'd0);
    expect_eq("abort_done", {31'd0, done}, 32'd0);
    expect_eq("abort_q", {8'd0, quotient}, 32'd0);
    expect_eq("abort_r", {20'd0, remainder}, 32'd0);
    expect_eq("abort_dbz", {31'd0, div_by_zero}, 32'd0);
    @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1'b1;
    end
    expect_eq("abort_no_done", {31'd0, seen}, 32'd0);

    run_vec("after_rst",1'b0, 24'd1000,     12'd7,    24'd142,      12'd6,   1'b0, 1'b0, 26, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
